// File: rtl/mem_copy_engine.sv
// Byte-serial block copy master for the single-port data memory: read cycle then write cycle per byte,
// Done 2*Len+1 cycles after Start is accepted; Start is ignored (not queued) while a copy is in flight.
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = AW + 1
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [LW-1:0] Len,
    output logic [AW-1:0] DataAddress,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    output logic          Busy,
    output logic          Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic [LW-1:0] idx_inc;
    logic [DW-1:0] data_buf;

    assign idx_inc = idx + LW'(1);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            src      <= '0;
            dst      <= '0;
            len      <= '0;
            idx      <= '0;
            data_buf <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        src <= SrcAddr;
                        dst <= DstAddr;
                        len <= Len;
                        idx <= '0;
                    end
                end
                S_READ:  data_buf <= MemRData;
                S_WRITE: idx      <= idx_inc;
                default: ;
            endcase
        end
    end

    // Address sums are truncated to AW bits so block copies wrap around the memory.
    always_comb begin
        state_nxt   = state;
        DataAddress = '0;
        ReadMem     = 1'b0;
        WriteMem    = 1'b0;
        MemWData    = '0;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt = (Len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                Busy        = 1'b1;
                ReadMem     = 1'b1;
                DataAddress = src + idx[AW-1:0];
                state_nxt   = S_WRITE;
            end
            S_WRITE: begin
                Busy        = 1'b1;
                WriteMem    = 1'b1;
                DataAddress = dst + idx[AW-1:0];
                MemWData    = data_buf;
                state_nxt   = (idx_inc == len) ? S_DONE : S_READ;
            end
            S_DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory plus a byte-by-byte reference copy of the whole array.
module tb_mem_copy_engine;

    logic       CLK;
    logic       Reset;
    logic       Start;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [8:0] Len;
    logic [7:0] DataAddress;
    logic       ReadMem;
    logic       WriteMem;
    logic [7:0] MemWData;
    logic [7:0] MemRData;
    logic       Busy;
    logic       Done;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    int done_cnt = 0;
    int viol    = 0;

    mem_copy_engine #(.AW(8), .DW(8), .LW(9)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Start       (Start),
        .SrcAddr     (SrcAddr),
        .DstAddr     (DstAddr),
        .Len         (Len),
        .DataAddress (DataAddress),
        .ReadMem     (ReadMem),
        .WriteMem    (WriteMem),
        .MemWData    (MemWData),
        .MemRData    (MemRData),
        .Busy        (Busy),
        .Done        (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign MemRData = mem[DataAddress];

    always @(posedge CLK) begin
        if (WriteMem) mem[DataAddress] <= MemWData;
    end

    always @(negedge CLK) begin
        if (ReadMem && WriteMem) viol++;
        if (ReadMem)  rd_cnt++;
        if (WriteMem) wr_cnt++;
        if (Done)     done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_byte(input logic [7:0] a, input logic [7:0] v);
        mem[a]     = v;
        exp_mem[a] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) set_byte(i[7:0], 8'($urandom));
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < 256; i++) check(tag, mem[i], exp_mem[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd"},   ReadMem, 0);
        check({tag, "_wr"},   WriteMem, 0);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_addr"}, DataAddress, 0);
        check({tag, "_wdat"}, MemWData, 0);
    endtask

    // Reference: strictly ascending byte copy, so overlapping blocks replicate written bytes.
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int l);
        logic [7:0] sa;
        logic [7:0] da;
        for (int i = 0; i < l; i++) begin
            sa = s + 8'(i);
            da = d + 8'(i);
            exp_mem[da] = exp_mem[sa];
        end
    endtask

    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input int l, input bit poke);
        int n;
        bit seen;
        model_copy(s, d, l);
        @(negedge CLK);
        Start = 1'b1; SrcAddr = s; DstAddr = d; Len = 9'(l);
        #1;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        n = 0; seen = 0;
        while (!seen && n < 600) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                Start = 1'b0;
                check("busy_after_start", Busy, 1);
            end
            if (poke && n == 3) begin
                Start = 1'b1; SrcAddr = ~s; DstAddr = ~d; Len = 9'd5;
            end
            if (poke && n == 5) Start = 1'b0;
            if (Done) seen = 1;
        end
        check("done_latency", n, 2 * l + 1);
        @(negedge CLK);
        #1;
        check("done_pulse", Done, 0);
        check("busy_idle", Busy, 0);
        check("rd_count", rd_cnt, l);
        check("wr_count", wr_cnt, l);
        check("done_count", done_cnt, 1);
        compare_mem("mem_copy");
    endtask

    initial begin
        int n;
        Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
        fill_random();
        #3;
        check_idle_outputs("reset");
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        // Basic copy
        set_byte(8'd10, 8'hA1); set_byte(8'd11, 8'hB2);
        set_byte(8'd12, 8'hC3); set_byte(8'd13, 8'hD4);
        run_copy(8'd10, 8'd40, 4, 0);
        // Zero length
        run_copy(8'd5, 8'd6, 0, 0);
        // Address wrap
        set_byte(8'd254, 8'd1); set_byte(8'd255, 8'd2);
        set_byte(8'd0, 8'd3);   set_byte(8'd1, 8'd4);
        run_copy(8'd254, 8'd100, 4, 0);
        // Overlap replication
        set_byte(8'd20, 8'd55);
        run_copy(8'd20, 8'd21, 3, 0);
        // Start while busy is ignored
        run_copy(8'd30, 8'd60, 6, 1);

        // Reset during the third write
        fill_random();
        exp_mem[128] = exp_mem[0];
        exp_mem[129] = exp_mem[1];
        @(negedge CLK);
        Start = 1'b1; SrcAddr = 8'd0; DstAddr = 8'd128; Len = 9'd8;
        n = 0;
        while (n < 6) begin
            @(negedge CLK);
            n++;
            Start = 1'b0;
        end
        #1;
        check("third_write_active", WriteMem, 1);
        check("third_write_addr", DataAddress, 130);
        Reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        done_cnt = 0;
        repeat (20) @(negedge CLK);
        #1;
        check("no_done_after_reset", done_cnt, 0);
        check("busy_after_reset", Busy, 0);
        compare_mem("mem_reset");

        // Randomised copies, including forced overlaps and zero lengths
        for (int t = 0; t < 20; t++) begin
            logic [7:0] s;
            logic [7:0] d;
            int l;
            fill_random();
            s = 8'($urandom);
            d = (t % 3 == 0) ? s + 8'($urandom_range(1, 4)) : 8'($urandom);
            l = (t % 7 == 0) ? 0 : $urandom_range(1, 24);
            run_copy(s, d, l, t % 4 == 1 && l >= 4);
        end

        check("rd_wr_exclusive", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
